// File: rtl/hkalm_lsu.sv
`default_nettype none
// ============================================================================
// Module   : hkalm_lsu
// Brief    : Load/store unit with valid/ready request, valid response,
//            byte-lane alignment, load extension and a response timeout.
// Revision : 1.0
// ============================================================================
module hkalm_lsu #(
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid_E,
    input  logic                 req_we_E,
    input  logic [2:0]           funct3_E,
    input  logic [ADDR_W-1:0]    addr_E,
    input  logic [XLEN-1:0]      wdata_E,
    output logic                 stall,
    output logic [XLEN-1:0]      rdata_M,
    output logic                 done_M,
    output logic                 misaligned,
    output logic                 bus_error,
    output logic                 mem_req_valid,
    input  logic                 mem_req_ready,
    output logic                 mem_we,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [XLEN-1:0]      mem_wdata,
    output logic [XLEN/8-1:0]    mem_be,
    input  logic                 mem_rsp_valid,
    input  logic [XLEN-1:0]      mem_rdata
);

    localparam int c_nb    = XLEN / 8;
    localparam int c_off_w = $clog2(c_nb);
    localparam int c_cnt_w = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [c_cnt_w-1:0] c_timeout = c_cnt_w'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               r_state;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_off_w-1:0]   r_off;
    logic [1:0]           r_size;
    logic                 r_uns;
    logic                 r_mem_req_valid;
    logic                 r_mem_we;
    logic [ADDR_W-1:0]    r_mem_addr;
    logic [XLEN-1:0]      r_mem_wdata;
    logic [c_nb-1:0]      r_mem_be;
    logic [XLEN-1:0]      r_rdata;
    logic                 r_done;
    logic                 r_misaligned;
    logic                 r_bus_error;

    logic [1:0]           w_size;
    logic [c_off_w-1:0]   w_off;
    logic                 w_bad_f3;
    logic                 w_addr_mis;
    logic                 w_aligned;
    logic [c_nb-1:0]      w_be_base;
    logic [XLEN-1:0]      w_lanes;

    // Right-aligned lanes masked to the access size, then sign/zero filled.
    function automatic logic [XLEN-1:0] load_extend(
        input logic [XLEN-1:0] lanes,
        input logic [1:0]      size,
        input logic            is_unsigned
    );
        logic [XLEN-1:0] mask;
        logic            sign;
        mask = '1;
        sign = 1'b0;
        case (size)
            2'd0: begin mask = XLEN'(64'hFF);        sign = lanes[7];  end
            2'd1: begin mask = XLEN'(64'hFFFF);      sign = lanes[15]; end
            2'd2: begin mask = XLEN'(64'hFFFF_FFFF); sign = lanes[31]; end
            default: begin mask = '1;                sign = 1'b0;      end
        endcase
        return (lanes & mask) | ({XLEN{sign & ~is_unsigned}} & ~mask);
    endfunction

    assign w_size = funct3_E[1:0];
    assign w_off  = addr_E[c_off_w-1:0];

    // 111 is never legal; 64-bit size and lwu exist only on RV64.
    assign w_bad_f3 = (funct3_E == 3'b111) ||
                      ((XLEN == 32) && ((funct3_E == 3'b011) || (funct3_E == 3'b110)));

    always_comb begin
        w_addr_mis = 1'b0;
        w_be_base  = '1;
        case (w_size)
            2'd0: begin w_addr_mis = 1'b0;          w_be_base = c_nb'(1);  end
            2'd1: begin w_addr_mis = addr_E[0];     w_be_base = c_nb'(3);  end
            2'd2: begin w_addr_mis = |addr_E[1:0];  w_be_base = c_nb'(15); end
            default: begin w_addr_mis = |addr_E[2:0]; w_be_base = '1;     end
        endcase
    end

    assign w_aligned = ~w_bad_f3 & ~w_addr_mis;
    assign w_lanes   = mem_rdata >> {r_off, 3'b000};

    assign stall = ((r_state == S_IDLE) & req_valid_E & w_aligned) |
                   (r_state == S_REQ) | (r_state == S_WAIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_cnt           <= '0;
            r_off           <= '0;
            r_size          <= '0;
            r_uns           <= 1'b0;
            r_mem_req_valid <= 1'b0;
            r_mem_we        <= 1'b0;
            r_mem_addr      <= '0;
            r_mem_wdata     <= '0;
            r_mem_be        <= '0;
            r_rdata         <= '0;
            r_done          <= 1'b0;
            r_misaligned    <= 1'b0;
            r_bus_error     <= 1'b0;
        end else begin
            r_done       <= 1'b0;
            r_misaligned <= 1'b0;
            r_bus_error  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid_E) begin
                        if (w_aligned) begin
                            r_off           <= w_off;
                            r_size          <= w_size;
                            r_uns           <= funct3_E[2];
                            r_mem_we        <= req_we_E;
                            r_mem_addr      <= {addr_E[ADDR_W-1:c_off_w], {c_off_w{1'b0}}};
                            r_mem_wdata     <= wdata_E << {w_off, 3'b000};
                            r_mem_be        <= w_be_base << w_off;
                            r_mem_req_valid <= 1'b1;
                            r_state         <= S_REQ;
                        end else begin
                            r_misaligned <= 1'b1;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_req_ready) begin
                        r_mem_req_valid <= 1'b0;
                        if (r_mem_we) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_cnt   <= '0;
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    // A response in the timeout cycle still wins.
                    if (mem_rsp_valid) begin
                        r_rdata <= load_extend(w_lanes, r_size, r_uns);
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else if ((TIMEOUT != 0) && (r_cnt == c_timeout)) begin
                        r_bus_error <= 1'b1;
                        r_rdata     <= '0;
                        r_state     <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_req_valid = r_mem_req_valid;
    assign mem_we        = r_mem_we;
    assign mem_addr      = r_mem_addr;
    assign mem_wdata     = r_mem_wdata;
    assign mem_be        = r_mem_be;
    assign rdata_M       = r_rdata;
    assign done_M        = r_done;
    assign misaligned    = r_misaligned;
    assign bus_error     = r_bus_error;

endmodule
`default_nettype wire

// File: tb/tb_hkalm_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_hkalm_lsu
// Brief    : Self-checking bench for hkalm_lsu, RV32 and RV64 instances.
// Revision : 1.0
// ============================================================================
module tb_hkalm_lsu;

    localparam int T32 = 4;
    localparam int T64 = 6;

    logic        clk;
    logic        reset;
    logic        sel;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic        ready;
    logic        rsp;
    logic [63:0] mrdata;

    logic        st32, dn32, mis32, be32e, mrv32, mwe32;
    logic [31:0] rd32, maddr32, mwd32;
    logic [3:0]  mbe32;
    logic        st64, dn64, mis64, be64e, mrv64, mwe64;
    logic [63:0] rd64, mwd64;
    logic [31:0] maddr64;
    logic [7:0]  mbe64;

    logic        o_stall, o_done, o_mis, o_berr, o_mrv, o_mwe;
    logic [63:0] o_rdata, o_mwd;
    logic [31:0] o_maddr;
    logic [7:0]  o_mbe;

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] last_rd [2];

    hkalm_lsu #(.XLEN(32), .ADDR_W(32), .TIMEOUT(T32)) u32 (
        .clk(clk), .reset(reset),
        .req_valid_E(req_valid & ~sel), .req_we_E(req_we), .funct3_E(f3),
        .addr_E(addr), .wdata_E(wdata[31:0]),
        .stall(st32), .rdata_M(rd32), .done_M(dn32), .misaligned(mis32),
        .bus_error(be32e), .mem_req_valid(mrv32), .mem_req_ready(ready),
        .mem_we(mwe32), .mem_addr(maddr32), .mem_wdata(mwd32), .mem_be(mbe32),
        .mem_rsp_valid(rsp), .mem_rdata(mrdata[31:0])
    );

    hkalm_lsu #(.XLEN(64), .ADDR_W(32), .TIMEOUT(T64)) u64 (
        .clk(clk), .reset(reset),
        .req_valid_E(req_valid & sel), .req_we_E(req_we), .funct3_E(f3),
        .addr_E(addr), .wdata_E(wdata),
        .stall(st64), .rdata_M(rd64), .done_M(dn64), .misaligned(mis64),
        .bus_error(be64e), .mem_req_valid(mrv64), .mem_req_ready(ready),
        .mem_we(mwe64), .mem_addr(maddr64), .mem_wdata(mwd64), .mem_be(mbe64),
        .mem_rsp_valid(rsp), .mem_rdata(mrdata)
    );

    assign o_stall = sel ? st64  : st32;
    assign o_done  = sel ? dn64  : dn32;
    assign o_mis   = sel ? mis64 : mis32;
    assign o_berr  = sel ? be64e : be32e;
    assign o_mrv   = sel ? mrv64 : mrv32;
    assign o_mwe   = sel ? mwe64 : mwe32;
    assign o_rdata = sel ? rd64  : {32'd0, rd32};
    assign o_mwd   = sel ? mwd64 : {32'd0, mwd32};
    assign o_maddr = sel ? maddr64 : maddr32;
    assign o_mbe   = sel ? mbe64 : {4'd0, mbe32};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        bit          s;
        logic [2:0]  f3;
        bit          we;
        logic [31:0] addr;
        logic [63:0] wd;
        logic [63:0] rd;
        int          k;
        int          d;
        bit          e_mis;
        logic [31:0] e_addr;
        logic [7:0]  e_be;
        logic [63:0] e_wd;
        logic [63:0] e_rd;
    } vec_t;

    vec_t tbl [17];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: byte arithmetic straight from the access rules.
    task automatic model(input bit s, input logic [2:0] fn, input logic [31:0] a,
                         input logic [63:0] wd, input logic [63:0] rd,
                         output bit mis, output logic [31:0] e_addr, output logic [7:0] e_be,
                         output logic [63:0] e_wd, output logic [63:0] e_rd);
        int xl, nb, nbytes, off, be_i;
        bit legal;
        logic [63:0] xmask, vmask, v;
        xl     = s ? 64 : 32;
        nb     = xl / 8;
        nbytes = 1 << fn[1:0];
        legal  = !(fn == 3'd7) && !(xl == 32 && (fn == 3'd3 || fn == 3'd6));
        mis    = !legal || ((a % nbytes) != 0);
        off    = int'(a % nb);
        e_addr = a - 32'(off);
        be_i   = ((1 << nbytes) - 1) << off;
        e_be   = 8'(be_i);
        xmask  = (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF;
        e_wd   = ((wd & xmask) << (8 * off)) & xmask;
        v      = (rd & xmask) >> (8 * off);
        vmask  = (nbytes == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nbytes)) - 64'd1);
        v      = v & vmask;
        if (!fn[2] && v[8 * nbytes - 1]) v = v | ~vmask;
        e_rd   = v & xmask;
    endtask

    task automatic access(input vec_t t);
        int  tmo;
        bit  rsp_ok;
        int  nwait;
        tmo = t.s ? T64 : T32;
        @(negedge clk);
        sel = t.s; req_valid = 1'b1; req_we = t.we; f3 = t.f3; addr = t.addr;
        wdata = t.wd; ready = 1'b0; rsp = 1'b0; mrdata = {$urandom, $urandom};
        #1;
        check("stall_idle_req", o_stall, !t.e_mis);
        if (t.e_mis) begin
            @(negedge clk); req_valid = 1'b0; #1;
            check("misaligned_pulse", o_mis, 1);
            check("mis_no_req", o_mrv, 0);
            check("mis_stall", o_stall, 0);
            @(negedge clk); #1;
            check("misaligned_clear", o_mis, 0);
            check("mis_no_req2", o_mrv, 0);
            return;
        end
        for (int i = 0; i <= t.k; i++) begin
            @(negedge clk); ready = (i == t.k); mrdata = {$urandom, $urandom}; #1;
            check("req_valid", o_mrv, 1);
            check("req_we", o_mwe, t.we);
            check("req_addr", o_maddr, t.e_addr);
            check("req_be", o_mbe, t.e_be);
            check("req_wdata", o_mwd, t.e_wd);
            check("req_stall", o_stall, 1);
            check("req_no_done", o_done, 0);
            check("req_no_mis", o_mis, 0);
        end
        if (!t.we) begin
            rsp_ok = (t.d >= 0) && (tmo == 0 || t.d <= tmo);
            nwait  = rsp_ok ? t.d : tmo;
            for (int j = 0; j <= nwait; j++) begin
                @(negedge clk); ready = 1'b0;
                rsp = rsp_ok && (j == t.d);
                mrdata = rsp ? t.rd : {$urandom, $urandom};
                #1;
                check("wait_stall", o_stall, 1);
                check("wait_no_req", o_mrv, 0);
                check("wait_no_done", o_done, 0);
                check("wait_no_berr", o_berr, 0);
            end
            if (!rsp_ok) begin
                @(negedge clk); rsp = 1'b0; req_valid = 1'b0; #1;
                check("bus_error_pulse", o_berr, 1);
                check("bus_error_rdata", o_rdata, 0);
                check("bus_error_no_done", o_done, 0);
                check("bus_error_stall", o_stall, 0);
                last_rd[t.s] = 64'd0;
                @(negedge clk); #1;
                check("bus_error_clear", o_berr, 0);
                return;
            end
            last_rd[t.s] = t.e_rd;
        end
        @(negedge clk); ready = 1'b0; rsp = 1'b0; mrdata = {$urandom, $urandom}; #1;
        check("done_pulse", o_done, 1);
        check("done_stall", o_stall, 0);
        check("done_rdata", o_rdata, last_rd[t.s]);
        check("done_no_req", o_mrv, 0);
        @(negedge clk); req_valid = 1'b0; #1;
        check("done_clear", o_done, 0);
        check("idle_stall", o_stall, 0);
    endtask

    initial begin
        vec_t v;
        sel = 1'b0; req_valid = 1'b0; req_we = 1'b0; f3 = 3'd0; addr = 32'd0;
        wdata = 64'd0; ready = 1'b0; rsp = 1'b0; mrdata = 64'd0;
        last_rd[0] = 64'd0; last_rd[1] = 64'd0;
        reset = 1'b1;

        //            s  f3      we addr       wd                      rd                       k  d  mis e_addr     be     e_wd                    e_rd
        tbl[0]  = '{0, 3'b010, 0, 32'h104, 64'h0,                  64'hDEADBEEF,            0, 2, 0, 32'h104, 8'h0F, 64'h0,                  64'hDEADBEEF};
        tbl[1]  = '{0, 3'b000, 0, 32'h203, 64'h0,                  64'h80FFFFFF,            1, 0, 0, 32'h200, 8'h08, 64'h0,                  64'hFFFFFF80};
        tbl[2]  = '{0, 3'b100, 0, 32'h203, 64'h0,                  64'h80FFFFFF,            0, 1, 0, 32'h200, 8'h08, 64'h0,                  64'h00000080};
        tbl[3]  = '{0, 3'b001, 1, 32'h012, 64'h0000ABCD,           64'h0,                   3, 0, 0, 32'h010, 8'h0C, 64'hABCD0000,           64'h0};
        tbl[4]  = '{0, 3'b010, 0, 32'h101, 64'h0,                  64'h0,                   0, 0, 1, 32'h0,   8'h00, 64'h0,                  64'h0};
        tbl[5]  = '{0, 3'b010, 0, 32'h040, 64'h0,                  64'h0,                   0,-1, 0, 32'h040, 8'h0F, 64'h0,                  64'h0};
        tbl[6]  = '{0, 3'b010, 0, 32'h044, 64'h0,                  64'h12345678,            0, 4, 0, 32'h044, 8'h0F, 64'h0,                  64'h12345678};
        tbl[7]  = '{0, 3'b011, 0, 32'h008, 64'h0,                  64'h0,                   0, 0, 1, 32'h0,   8'h00, 64'h0,                  64'h0};
        tbl[8]  = '{1, 3'b111, 0, 32'h000, 64'h0,                  64'h0,                   0, 0, 1, 32'h0,   8'h00, 64'h0,                  64'h0};
        tbl[9]  = '{1, 3'b011, 0, 32'h008, 64'h0,                  64'h0123456789ABCDEF,    0, 1, 0, 32'h008, 8'hFF, 64'h0,                  64'h0123456789ABCDEF};
        tbl[10] = '{1, 3'b110, 0, 32'h00C, 64'h0,                  64'hF0000000_00000000,   0, 0, 0, 32'h008, 8'hF0, 64'h0,                  64'h00000000_F0000000};
        tbl[11] = '{1, 3'b010, 0, 32'h004, 64'h0,                  64'h80000000_00000000,   2, 3, 0, 32'h000, 8'hF0, 64'h0,                  64'hFFFFFFFF_80000000};
        tbl[12] = '{1, 3'b011, 1, 32'h010, 64'h1122334455667788,   64'h0,                   1, 0, 0, 32'h010, 8'hFF, 64'h1122334455667788,   64'h0};
        tbl[13] = '{1, 3'b000, 1, 32'h007, 64'h00000000000000AB,   64'h0,                   0, 0, 0, 32'h000, 8'h80, 64'hAB000000_00000000,  64'h0};
        tbl[14] = '{0, 3'b001, 0, 32'h002, 64'h0,                  64'h80010000,            0, 0, 0, 32'h000, 8'h0C, 64'h0,                  64'hFFFF8001};
        tbl[15] = '{1, 3'b101, 0, 32'h003, 64'h0,                  64'h0,                   0, 0, 1, 32'h0,   8'h00, 64'h0,                  64'h0};
        tbl[16] = '{1, 3'b100, 0, 32'h001, 64'h0,                  64'h0,                   1,-1, 0, 32'h000, 8'h02, 64'h0,                  64'h0};

        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0]; #1;
            check("reset_req_valid", o_mrv, 0);
            check("reset_we", o_mwe, 0);
            check("reset_addr", o_maddr, 0);
            check("reset_wdata", o_mwd, 0);
            check("reset_be", o_mbe, 0);
            check("reset_rdata", o_rdata, 0);
            check("reset_done", o_done, 0);
            check("reset_mis", o_mis, 0);
            check("reset_berr", o_berr, 0);
            check("reset_stall", o_stall, 0);
        end
        @(negedge clk); reset = 1'b0;

        for (int i = 0; i < 17; i++) access(tbl[i]);

        // Reset in the middle of a load wait, then a stray late response.
        @(negedge clk);
        sel = 1'b0; req_valid = 1'b1; req_we = 1'b0; f3 = 3'b010; addr = 32'h100; ready = 1'b0;
        @(negedge clk); ready = 1'b1;
        @(negedge clk); ready = 1'b0;
        @(negedge clk); #1;
        check("pre_reset_wait_stall", o_stall, 1);
        req_valid = 1'b0; #1; reset = 1'b1; #1;
        check("async_reset_stall", o_stall, 0);
        check("async_reset_addr", o_maddr, 0);
        check("async_reset_be", o_mbe, 0);
        check("async_reset_rdata", o_rdata, 0);
        check("async_reset_req", o_mrv, 0);
        @(negedge clk); reset = 1'b0; rsp = 1'b1; mrdata = 64'h55;
        last_rd[0] = 64'd0; last_rd[1] = 64'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); rsp = 1'b0; #1;
            check("late_rsp_no_done", o_done, 0);
            check("late_rsp_rdata", o_rdata, 0);
            check("late_rsp_stall", o_stall, 0);
        end

        for (int n = 0; n < 200; n++) begin
            logic [31:0] m;
            v.s  = 1'($urandom_range(0, 1));
            v.we = 1'($urandom_range(0, 1));
            v.f3 = 3'($urandom_range(0, 7));
            if (v.we) v.f3[2] = 1'b0;
            v.addr = 32'($urandom_range(0, 4095));
            m = (32'd1 << v.f3[1:0]) - 32'd1;
            if ($urandom_range(0, 3) != 0) v.addr = v.addr & ~m;
            v.wd = {$urandom, $urandom};
            v.rd = {$urandom, $urandom};
            v.k  = int'($urandom_range(0, 3));
            v.d  = int'($urandom_range(0, 8)) - 1;
            model(v.s, v.f3, v.addr, v.wd, v.rd, v.e_mis, v.e_addr, v.e_be, v.e_wd, v.e_rd);
            access(v);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hkalm_lsu.md
Name: hkalm_lsu

Overview:
- Parametrised load/store unit that sits between the core's execute stage and a data memory with variable latency.
- Replaces the fixed single-cycle data-memory interface with a valid/ready request channel and a valid response channel.
- Adds byte-lane alignment, load sign/zero extension, misalignment detection, a pipeline stall output and a response timeout.
- Datapath width is parametrised for RV32 or RV64.

Parameters:
- XLEN, 32, data width in bits (32 or 64); the byte-lane count is XLEN/8.
- ADDR_W, 32, address width.
- TIMEOUT, 255, maximum number of WAIT cycles before a bus error; 0 disables the timeout.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid_E  in  1  memory instruction present in the execute stage.
- req_we_E  in  1  1 = store, 0 = load.
- funct3_E  in  3  size/sign: 000 lb/sb, 001 lh/sh, 010 lw/sw, 011 ld/sd (only when XLEN=64), 100 lbu, 101 lhu, 110 lwu (only when XLEN=64).
- addr_E  in  ADDR_W  byte address.
- wdata_E  in  XLEN  store data, right-aligned.
- stall  out  1  holds the pipeline front end.
- rdata_M  out  XLEN  extended load result.
- done_M  out  1  one-cycle pulse when the access completes.
- misaligned  out  1  one-cycle pulse on an unaligned access.
- bus_error  out  1  one-cycle pulse on timeout.
- mem_req_valid  out  1  memory request valid.
- mem_req_ready  in  1  memory accepts the request.
- mem_we  out  1  write enable.
- mem_addr  out  ADDR_W  address with the low log2(XLEN/8) bits forced to 0.
- mem_wdata  out  XLEN  store data shifted into its byte lanes.
- mem_be  out  XLEN/8  byte enables.
- mem_rsp_valid  in  1  read data valid.
- mem_rdata  in  XLEN  read data, full word.

Behaviour:
- Clocking and reset: one clock domain (clk). reset is asynchronous, active-high.
- Reset values:
  - state = IDLE.
  - All registered outputs = 0: mem_req_valid, mem_we, mem_addr, mem_wdata, mem_be, rdata_M, done_M, misaligned, bus_error.
  - Timeout counter = 0.
  - Reset mid-transaction drops the access; any later mem_rsp_valid is ignored while in IDLE.
- FSM states:
  - IDLE:
    - If req_valid_E and the access is aligned: register we, size, sign, lane offset, aligned address, shifted wdata and byte enables; go to REQ.
    - If req_valid_E and the access is misaligned: misaligned=1 for one cycle, no memory access, stay in IDLE.
  - REQ:
    - mem_req_valid=1; all request fields are held stable until ready.
    - When mem_req_ready=1: a store goes to DONE; a load goes to WAIT with counter=0.
  - WAIT:
    - When mem_rsp_valid=1: select lanes by the registered offset, sign- or zero-extend into rdata_M, go to DONE.
    - Otherwise the counter increments. When counter==TIMEOUT (and TIMEOUT!=0): bus_error=1 for one cycle, rdata_M=0, go to IDLE.
    - A response and the timeout arriving in the same cycle resolve to the response.
  - DONE: done_M=1 for one cycle; go to IDLE. req_valid_E is ignored in DONE (the same instruction is still in E).
- Stall rule (combinational):
  - stall = (IDLE & req_valid_E & aligned) | REQ | WAIT.
  - stall = 0 in DONE, and 0 on a misaligned access.
- Latency:
  - Store: 1 cycle to REQ, plus k ready-wait cycles, plus DONE. Minimum 3 cycles from req_valid_E to done_M.
  - Load: adds the response-wait cycles on top of the store latency.
- Alignment rules:
  - Halfword needs addr[0]=0.
  - Word needs addr[1:0]=0.
  - Doubleword needs addr[2:0]=0.
  - funct3 011/110 with XLEN=32, and funct3 111, are flagged as misaligned.
- Byte enables: be = ((1<<bytes)-1) << offset, where offset = addr mod (XLEN/8). wdata is shifted left by 8*offset.
- mem_rdata is ignored outside WAIT.
- rdata_M holds its value until the next load completes.

Test Plan:
- lw, addr=0x104, mem_req_ready immediate, response 2 cycles later with rdata=0xDEADBEEF:
  - mem_addr=0x104, mem_be=1111; rdata_M=0xDEADBEEF; done_M pulses once.
  - stall high for exactly the REQ and WAIT cycles.
- lb, addr=0x203, mem_rdata=0x80FFFFFF -> rdata_M=0xFFFFFF80.
- lbu, addr=0x203, mem_rdata=0x80FFFFFF -> rdata_M=0x00000080.
- sh, addr=0x12, wdata=0x0000ABCD, ready held low 3 cycles -> mem_be=1100, mem_wdata=0xABCD0000; request fields stable throughout; done_M 1 cycle after ready.
- lw, addr=0x101 -> misaligned pulse, no mem_req_valid, stall stays 0.
- TIMEOUT=4, load with no response -> bus_error after 5 WAIT cycles, state back to IDLE.
- Reset asserted during WAIT:
  - All outputs go to 0 immediately.
  - A late mem_rsp_valid produces no done_M.
- XLEN=64: ld at addr 0x8 -> mem_be=0xFF. lwu at addr 0xC with rdata=0xF0000000_00000000 -> rdata_M=0x00000000_F0000000.
